// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared FSM encoding, constants and port-slicing helper
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic RST_ACTIVE = 1'b0;

   // Widest field and packed bus the slicing helper handles (4 ports x 64 bits).
   localparam int MAX_W = 64;
   localparam int BUS_W = MAX_W * 4;

   localparam logic [MAX_W-1:0] ZERO_WORD = '0;

   function automatic logic [MAX_W-1:0] slice_field(input logic [BUS_W-1:0] bus,
                                                   input int               idx,
                                                   input int               w);
      logic [BUS_W-1:0] shifted;
      shifted = bus >> (idx * w);
      return shifted[MAX_W-1:0] & ({MAX_W{1'b1}} >> (MAX_W - w));
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ============================================================================
// regfile_rd_port : one combinational read port with gating and bypass
// Revision        : 1.0
// ============================================================================
`default_nettype none

module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                           gate,
   input  logic                           rd_en,
   input  logic [ADDR_W-1:0]              rd_addr,
   input  logic                           we0,
   input  logic [ADDR_W-1:0]              waddr0,
   input  logic [DATA_W-1:0]              wdata0,
   input  logic                           we1,
   input  logic [ADDR_W-1:0]              waddr1,
   input  logic [DATA_W-1:0]              wdata1,
   input  logic [(2**ADDR_W)*DATA_W-1:0]  mem_flat,
   output logic [DATA_W-1:0]              rd_data
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] stored;
   logic              zero_hit;
   logic              hit0;
   logic              hit1;

   always_comb begin
      stored = ZERO_WORD[DATA_W-1:0];
      for (int e = 0; e < DEPTH; e++) begin
         if (rd_addr == ADDR_W'(e)) begin
            stored = mem_flat[e*DATA_W +: DATA_W];
         end
      end
   end

   assign zero_hit = (ZERO_REG != 0) && (rd_addr == '0);
   assign hit1     = (BYPASS != 0) && we1 && (waddr1 == rd_addr);
   assign hit0     = (BYPASS != 0) && we0 && (waddr0 == rd_addr);

   // Port 1 wins the bypass, mirroring its priority at the storage array.
   always_comb begin
      rd_data = ZERO_WORD[DATA_W-1:0];
      if (gate || !rd_en || zero_hit) begin
         rd_data = ZERO_WORD[DATA_W-1:0];
      end else if (hit1) begin
         rd_data = wdata1;
      end else if (hit0) begin
         rd_data = wdata0;
      end else begin
         rd_data = stored;
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp : parametrised 2-write / N-read register file with clear sequencer
// Revision   : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        waddr0,
   input  logic [DATA_W-1:0]        wdata0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        waddr1,
   input  logic [DATA_W-1:0]        wdata1,
   output logic                     init_busy,
   output logic                     wr_drop
);

   localparam int DEPTH = 2**ADDR_W;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic                init_busy_q, init_busy_d;
   logic                wr_drop_q, wr_drop_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];
   logic [DEPTH*DATA_W-1:0] mem_flat;
   logic                rd_gate;
   logic                wr0_ok;
   logic                wr1_ok;

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      init_busy_d = init_busy_q;
      wr_drop_d   = 1'b0;
      case (state_q)
         ST_INIT: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            wr_drop_d = we0 | we1;
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d     = ST_RUN;
               init_busy_d = 1'b0;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d     = ST_INIT;
            clr_cnt_d   = '0;
            init_busy_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ACTIVE) begin
         state_q     <= ST_INIT;
         clr_cnt_q   <= '0;
         init_busy_q <= 1'b1;
         wr_drop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         init_busy_q <= init_busy_d;
         wr_drop_q   <= wr_drop_d;
      end
   end

   assign wr0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
   assign wr1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

   // Port 1 is applied last so it overwrites port 0 on an address collision.
   always_comb begin
      mem_d = mem_q;
      if (state_q == ST_INIT) begin
         mem_d[clr_cnt_q] = ZERO_WORD[DATA_W-1:0];
      end else begin
         if (wr0_ok) begin
            mem_d[waddr0] = wdata0;
         end
         if (wr1_ok) begin
            mem_d[waddr1] = wdata1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst != RST_ACTIVE) begin
         mem_q <= mem_d;
      end
   end

   generate
      for (genvar e = 0; e < DEPTH; e++) begin : g_flat
         assign mem_flat[e*DATA_W +: DATA_W] = mem_q[e];
      end
   endgenerate

   assign rd_gate = (rst == RST_ACTIVE) || init_busy_q;

   generate
      for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
         logic [ADDR_W-1:0] port_addr;
         logic [DATA_W-1:0] port_data;

         assign port_addr = ADDR_W'(slice_field(BUS_W'(rd_addr), i, ADDR_W));

         regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
         ) u_rd_port (
            .gate     (rd_gate),
            .rd_en    (rd_en[i]),
            .rd_addr  (port_addr),
            .we0      (we0),
            .waddr0   (waddr0),
            .wdata0   (wdata0),
            .we1      (we1),
            .waddr1   (waddr1),
            .wdata1   (wdata1),
            .mem_flat (mem_flat),
            .rd_data  (port_data)
         );

         assign rd_data[i*DATA_W +: DATA_W] = port_data;
      end
   endgenerate

   assign init_busy = init_busy_q;
   assign wr_drop   = wr_drop_q;

endmodule

`default_nettype wire
